fighter_action_arb: RTL and testbench
=====================================

FIGHTER_ACTION_ARB -- requirements
Module: fighter_action_arb

Interface
REQ-001 The block SHALL have parameter BOUND_X_MAX, default 638, the right screen bound in pixels.
REQ-002 The block SHALL have parameter SPRITE_W, default 125, the player sprite width in pixels.
REQ-003 The block SHALL have parameter WALK_STEP, default 2, the walk displacement per frame.
REQ-004 The block SHALL have parameter COOLDOWN_FRAMES, default 8, the post-attack recovery length in frames.
REQ-005 The block SHALL have parameter HITSTUN_FRAMES, default 12, the hit-stun length in frames.
REQ-006 The block SHALL have port clk, input, 1 bit, the single system clock.
REQ-007 The block SHALL have port Reset, input, 1 bit, asynchronous active-high reset.
REQ-008 The block SHALL have port frame_tick, input, 1 bit, a one-cycle frame-advance strobe.
REQ-009 The block SHALL have ports punch_req, kick_req, walk_l, walk_r, crouch and hit, each input, 1 bit, the player request and hit-event levels.
REQ-010 The block SHALL have port xpos, input, 10 bits unsigned, the player left edge.
REQ-011 The block SHALL have port x_motion, output, 11 bits signed, the per-frame X displacement.
REQ-012 The block SHALL have port action, output, 3 bits, encoded as 0 IDLE, 1 WALK, 2 PUNCH, 3 KICK, 4 RECOVER, 5 HITSTUN.
REQ-013 The block SHALL have port busy, output, 1 bit, high in PUNCH, KICK, RECOVER and HITSTUN.

Function
REQ-014 State, counters and x_motion SHALL update only on clk edges with frame_tick=1 and SHALL hold otherwise; all outputs SHALL be registered.
REQ-015 wall_dist SHALL be BOUND_X_MAX-(xpos+SPRITE_W), computed signed at 12 bits or wider.
REQ-016 In IDLE/WALK, request priority SHALL be hit > crouch > punch > kick > walk.
REQ-017 crouch=1 in IDLE or WALK SHALL force IDLE with x_motion=0.
REQ-018 punch_req SHALL enter PUNCH at frame 0; frames 0..5 SHALL request motions 9,8,7,6,5,4, after which the state SHALL go to RECOVER.
REQ-019 kick_req SHALL enter KICK; frames 0..3 SHALL request motion 6, after which the state SHALL go to RECOVER.
REQ-020 During an attack, if the requested motion exceeds wall_dist, x_motion SHALL be max(wall_dist,0) and the next state SHALL be RECOVER.
REQ-021 An attack SHALL preempt WALK on the same tick and SHALL be interruptible only by hit.
REQ-022 walk_r alone SHALL give x_motion = min(WALK_STEP, max(wall_dist,0)); walk_l alone SHALL give x_motion = -min(WALK_STEP, xpos); both walk inputs or neither SHALL give IDLE with motion 0.
REQ-023 RECOVER SHALL last COOLDOWN_FRAMES ticks with x_motion=0 and all requests except hit ignored, then go to IDLE.
REQ-024 hit=1 on a tick in any state SHALL enter HITSTUN, load the counter with HITSTUN_FRAMES, and set x_motion = -min(3, xpos).
REQ-025 A hit during HITSTUN SHALL reload the counter.
REQ-026 HITSTUN SHALL produce x_motion=0 after the first frame and SHALL go to IDLE when the counter expires.
REQ-027 Requests SHALL be level-sampled at ticks, and a request held through RECOVER SHALL start a new action on the first IDLE tick.

Reset
REQ-028 Reset=1 SHALL asynchronously force IDLE, x_motion=0, action=0, busy=0 and all counters to 0, including when asserted mid-action.
REQ-029 The first tick after Reset deasserts SHALL evaluate requests from IDLE.

Configuration
REQ-030 With macro FIGHTER_ARB_COOLDOWN_EN defined, RECOVER SHALL behave per REQ-023.
REQ-031 With FIGHTER_ARB_COOLDOWN_EN undefined, attacks SHALL go directly to IDLE, RECOVER SHALL be unreachable, and action SHALL never equal 4.

Verification
REQ-032 The bench SHALL cover: xpos=100, punch_req held one tick -> x_motion 9,8,7,6,5,4 on successive ticks, then 8 ticks of RECOVER with busy=1, then IDLE.
REQ-033 The bench SHALL cover: xpos=505 (wall_dist 8), punch -> x_motion 8 on the first tick, then 0 on the next two ticks (wall_dist=0), then RECOVER.
REQ-034 The bench SHALL cover: walk_r held plus punch_req on the 3rd tick -> +2,+2, then 9; and walk_l at xpos=1 -> x_motion -1.
REQ-035 The bench SHALL cover: hit during KICK frame 2 at xpos=50 -> HITSTUN with x_motion -3, then 0 for 11 ticks, then IDLE; and hit again at HITSTUN tick 5 -> 12 more ticks.
REQ-036 The bench SHALL cover: crouch and punch_req together -> action 0, x_motion 0; and frame_tick held low with punch_req=1 -> no state change.
REQ-037 The bench SHALL cover: Reset asserted mid-PUNCH between clock edges -> outputs cleared immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/fighter_action_arb.sv
// fighter_action_arb
// ------------------
// Frame-rate action arbiter for one fighting-game player. On every clk edge
// with frame_tick=1 it picks the player's action (idle, walk, punch, kick,
// post-attack recovery, hit-stun) and the X displacement to apply this frame.
// Attack and walk motion toward the right bound is clipped against the
// distance left to the wall. Hit push-back and left walking are clipped
// against the left screen edge.
//
// Ports
//   clk         system clock
//   Reset       asynchronous active-high reset
//   frame_tick  one-cycle frame-advance strobe; nothing changes without it
//   punch_req, kick_req, walk_l, walk_r, crouch, hit
//               request / event levels, sampled on frame ticks
//   xpos        player left edge in pixels (unsigned)
//   x_motion    signed per-frame X displacement (registered)
//   action      0 IDLE, 1 WALK, 2 PUNCH, 3 KICK, 4 RECOVER, 5 HITSTUN (registered)
//   busy        high in PUNCH, KICK, RECOVER and HITSTUN (registered)
//
// Configuration
//   FIGHTER_ARB_COOLDOWN_EN  when defined, a finished attack spends
//                            COOLDOWN_FRAMES frames in RECOVER before
//                            returning to IDLE. When undefined, attacks return
//                            straight to IDLE and RECOVER is never entered.

module fighter_action_arb #(
   parameter int BOUND_X_MAX     = 638,
   parameter int SPRITE_W        = 125,
   parameter int WALK_STEP       = 2,
   parameter int COOLDOWN_FRAMES = 8,
   parameter int HITSTUN_FRAMES  = 12
) (
   input  logic               clk,
   input  logic               Reset,
   input  logic               frame_tick,
   input  logic               punch_req,
   input  logic               kick_req,
   input  logic               walk_l,
   input  logic               walk_r,
   input  logic               crouch,
   input  logic               hit,
   input  logic [9:0]         xpos,
   output logic signed [10:0] x_motion,
   output logic [2:0]         action,
   output logic               busy
);

   localparam int PUNCH_FRAMES = 6;
   localparam int KICK_FRAMES  = 4;
   localparam int HIT_PUSH     = 3;

   // One counter serves as the attack frame index and as the recovery /
   // hit-stun countdown, so it must hold the largest of those values.
   localparam int CNT_MAX_A = (HITSTUN_FRAMES > COOLDOWN_FRAMES) ? HITSTUN_FRAMES : COOLDOWN_FRAMES;
   localparam int CNT_MAX   = (CNT_MAX_A > PUNCH_FRAMES) ? CNT_MAX_A : PUNCH_FRAMES;
   localparam int CNT_W     = $clog2(CNT_MAX + 1);

   localparam logic signed [12:0] BOUND_S = 13'(BOUND_X_MAX);
   localparam logic signed [12:0] WIDTH_S = 13'(SPRITE_W);
   localparam logic signed [12:0] STEP_S  = 13'(WALK_STEP);
   localparam logic signed [12:0] PUSH_S  = 13'(HIT_PUSH);

   localparam logic [CNT_W-1:0] PUNCH_LAST = CNT_W'(PUNCH_FRAMES);
   localparam logic [CNT_W-1:0] KICK_LAST  = CNT_W'(KICK_FRAMES);
   localparam logic [CNT_W-1:0] HIT_LOAD   = CNT_W'(HITSTUN_FRAMES);
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WALK    = 3'd1,
      PUNCH   = 3'd2,
      KICK    = 3'd3,
      RECOVER = 3'd4,
      HITSTUN = 3'd5
   } action_t;

`ifdef FIGHTER_ARB_COOLDOWN_EN
   localparam action_t          ATTACK_END     = RECOVER;
   localparam logic [CNT_W-1:0] ATTACK_END_CNT = CNT_W'(COOLDOWN_FRAMES);
`else
   localparam action_t          ATTACK_END     = IDLE;
   localparam logic [CNT_W-1:0] ATTACK_END_CNT = '0;
`endif

   action_t            state;
   action_t            next_state;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   next_cnt;
   logic signed [10:0] next_x;
   logic               next_busy;

   logic signed [12:0] xpos_s;
   logic signed [12:0] cnt_s;
   logic signed [12:0] wall_dist;
   logic signed [12:0] wall_room;
   logic signed [12:0] atk_mot;
   logic signed [12:0] walk_r_mot;
   logic signed [12:0] walk_l_mot;
   logic signed [12:0] push_mot;
   logic               clamp;
   logic               walk_one;

   // Geometry: distance from the sprite's right edge to the right bound. It
   // goes negative when the sprite already overlaps the bound, so motion
   // toward the wall uses the non-negative wall_room.
   assign xpos_s     = $signed(13'(xpos));
   assign cnt_s      = $signed(13'(cnt));
   assign wall_dist  = BOUND_S - (xpos_s + WIDTH_S);
   assign wall_room  = wall_dist[12] ? 13'sd0 : wall_dist;
   assign walk_r_mot = (STEP_S < wall_room) ? STEP_S : wall_room;
   assign walk_l_mot = (STEP_S < xpos_s) ? STEP_S : xpos_s;
   assign push_mot   = (PUSH_S < xpos_s) ? PUSH_S : xpos_s;
   assign walk_one   = walk_l ^ walk_r;

   // Motion the attack frame executed on this tick would ask for. In PUNCH
   // the counter holds the index of the frame about to run. From IDLE/WALK it
   // is frame 0 of whichever attack wins priority.
   always_comb begin
      atk_mot = 13'sd6;
      if (state == PUNCH) begin
         atk_mot = 13'sd9 - cnt_s;
      end else if (state == KICK) begin
         atk_mot = 13'sd6;
      end else if (punch_req) begin
         atk_mot = 13'sd9;
      end
   end

   // An attack frame that would run into the wall stops at the wall and ends
   // the attack on the following frame.
   assign clamp = (atk_mot > wall_dist);

   // State register: everything advances on frame ticks only.
   always_ff @(posedge clk or posedge Reset) begin
      if (Reset) begin
         state    <= IDLE;
         cnt      <= '0;
         x_motion <= '0;
         busy     <= 1'b0;
      end else if (frame_tick) begin
         state    <= next_state;
         cnt      <= next_cnt;
         x_motion <= next_x;
         busy     <= next_busy;
      end
   end

   // Next-state logic. A hit wins in every state. Attacks end on the frame
   // after their last one, and a wall clamp jumps the counter straight to
   // that terminal value so the attack ends on the next frame.
   // RECOVER and HITSTUN count down and leave when the count reaches one,
   // which gives exactly N displayed frames for a load of N.
   always_comb begin
      next_state = state;
      next_cnt   = cnt;
      if (hit) begin
         next_state = HITSTUN;
         next_cnt   = HIT_LOAD;
      end else begin
         case (state)
            IDLE, WALK: begin
               next_cnt = '0;
               if (crouch) begin
                  next_state = IDLE;
               end else if (punch_req) begin
                  next_state = PUNCH;
                  next_cnt   = clamp ? PUNCH_LAST : CNT_ONE;
               end else if (kick_req) begin
                  next_state = KICK;
                  next_cnt   = clamp ? KICK_LAST : CNT_ONE;
               end else if (walk_one) begin
                  next_state = WALK;
               end else begin
                  next_state = IDLE;
               end
            end
            PUNCH: begin
               if (cnt >= PUNCH_LAST) begin
                  next_state = ATTACK_END;
                  next_cnt   = ATTACK_END_CNT;
               end else begin
                  next_cnt = clamp ? PUNCH_LAST : cnt + CNT_ONE;
               end
            end
            KICK: begin
               if (cnt >= KICK_LAST) begin
                  next_state = ATTACK_END;
                  next_cnt   = ATTACK_END_CNT;
               end else begin
                  next_cnt = clamp ? KICK_LAST : cnt + CNT_ONE;
               end
            end
            RECOVER, HITSTUN: begin
               if (cnt <= CNT_ONE) begin
                  next_state = IDLE;
                  next_cnt   = '0;
               end else begin
                  next_cnt = cnt - CNT_ONE;
               end
            end
            default: begin
               next_state = IDLE;
               next_cnt   = '0;
            end
         endcase
      end
   end

   // Output logic: motion and busy for the frame being entered. Any frame
   // that lands in PUNCH/KICK is an executed attack frame, and HITSTUN only
   // pushes back on the tick the hit arrives.
   always_comb begin
      next_x    = '0;
      next_busy = 1'b0;
      case (next_state)
         WALK: begin
            next_x = walk_r ? 11'(walk_r_mot) : 11'(-walk_l_mot);
         end
         PUNCH, KICK: begin
            next_x    = clamp ? 11'(wall_room) : 11'(atk_mot);
            next_busy = 1'b1;
         end
         RECOVER: begin
            next_busy = 1'b1;
         end
         HITSTUN: begin
            next_x    = hit ? 11'(-push_mot) : 11'sd0;
            next_busy = 1'b1;
         end
         default: begin
            next_x    = '0;
            next_busy = 1'b0;
         end
      endcase
   end

   assign action = state;

endmodule

// File: tb/tb_fighter_action_arb.sv
// tb_fighter_action_arb
// ---------------------
// Directed bench for fighter_action_arb with default parameters. Expected
// values are worked out by hand from the default geometry
// (BOUND_X_MAX=638, SPRITE_W=125, so wall_dist = 513 - xpos).
// Recovery expectations follow FIGHTER_ARB_COOLDOWN_EN the same way the
// design does.

module tb_fighter_action_arb;

   logic               clk = 1'b0;
   logic               Reset;
   logic               frame_tick;
   logic               punch_req;
   logic               kick_req;
   logic               walk_l;
   logic               walk_r;
   logic               crouch;
   logic               hit;
   logic [9:0]         xpos;
   logic signed [10:0] x_motion;
   logic [2:0]         action;
   logic               busy;

   int compared   = 0;
   int mismatched = 0;

`ifdef FIGHTER_ARB_COOLDOWN_EN
   localparam logic [2:0] END_ACTION = 3'd4;
`else
   localparam logic [2:0] END_ACTION = 3'd0;
`endif

   fighter_action_arb dut (
      .clk        (clk),
      .Reset      (Reset),
      .frame_tick (frame_tick),
      .punch_req  (punch_req),
      .kick_req   (kick_req),
      .walk_l     (walk_l),
      .walk_r     (walk_r),
      .crouch     (crouch),
      .hit        (hit),
      .xpos       (xpos),
      .x_motion   (x_motion),
      .action     (action),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // One frame: strobe frame_tick across a single rising edge, then sample
   // 1 time unit after that edge.
   task automatic tick();
      frame_tick = 1'b1;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
   endtask

   task automatic do_reset();
      Reset      = 1'b1;
      frame_tick = 1'b0;
      punch_req  = 1'b0;
      kick_req   = 1'b0;
      walk_l     = 1'b0;
      walk_r     = 1'b0;
      crouch     = 1'b0;
      hit        = 1'b0;
      @(posedge clk);
      #1;
      Reset = 1'b0;
   endtask

   task automatic test_reset();
      Reset      = 1'b1;
      frame_tick = 1'b1;
      punch_req  = 1'b1;
      xpos       = 10'd100;
      @(posedge clk);
      #1;
      @(posedge clk);
      #1;
      compared++;
      if (action !== 3'd0) begin
         mismatched++;
         $display("[TB] FAIL reset_action: got %0d expected 0", action);
      end
      compared++;
      if (x_motion !== 11'sd0) begin
         mismatched++;
         $display("[TB] FAIL reset_x: got %0d expected 0", x_motion);
      end
      compared++;
      if (busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL reset_busy: got %0b expected 0", busy);
      end
      punch_req = 1'b0;
   endtask

   task automatic test_punch_sequence();
      logic signed [10:0] ex;
      do_reset();
      xpos      = 10'd100;
      punch_req = 1'b1;
      tick();
      punch_req = 1'b0;
      for (int f = 0; f < 6; f++) begin
         if (f != 0) tick();
         ex = 11'(9 - f);
         compared++;
         if (x_motion !== ex || action !== 3'd2 || busy !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL punch_frame%0d: got x=%0d act=%0d busy=%0b expected x=%0d act=2 busy=1",
                     f, x_motion, action, busy, ex);
         end
      end
`ifdef FIGHTER_ARB_COOLDOWN_EN
      for (int i = 0; i < 8; i++) begin
         tick();
         compared++;
         if (action !== 3'd4 || busy !== 1'b1 || x_motion !== 11'sd0) begin
            mismatched++;
            $display("[TB] FAIL punch_recover%0d: got act=%0d busy=%0b x=%0d expected act=4 busy=1 x=0",
                     i, action, busy, x_motion);
         end
      end
`endif
      tick();
      compared++;
      if (action !== 3'd0 || busy !== 1'b0 || x_motion !== 11'sd0) begin
         mismatched++;
         $display("[TB] FAIL punch_to_idle: got act=%0d busy=%0b x=%0d expected act=0 busy=0 x=0",
                  action, busy, x_motion);
      end
   endtask

   task automatic test_held_request();
      do_reset();
      xpos     = 10'd100;
      kick_req = 1'b1;
      for (int f = 0; f < 4; f++) begin
         tick();
         compared++;
         if (action !== 3'd3 || x_motion !== 11'sd6) begin
            mismatched++;
            $display("[TB] FAIL kick_frame%0d: got act=%0d x=%0d expected act=3 x=6", f, action, x_motion);
         end
      end
`ifdef FIGHTER_ARB_COOLDOWN_EN
      for (int i = 0; i < 8; i++) begin
         tick();
         compared++;
         if (action !== 3'd4) begin
            mismatched++;
            $display("[TB] FAIL held_recover%0d: got act=%0d expected 4", i, action);
         end
      end
`endif
      tick();
      compared++;
      if (action !== 3'd0 || x_motion !== 11'sd0) begin
         mismatched++;
         $display("[TB] FAIL held_idle: got act=%0d x=%0d expected act=0 x=0", action, x_motion);
      end
      tick();
      compared++;
      if (action !== 3'd3 || x_motion !== 11'sd6) begin
         mismatched++;
         $display("[TB] FAIL held_restart: got act=%0d x=%0d expected act=3 x=6", action, x_motion);
      end
      kick_req = 1'b0;
   endtask

   task automatic test_wall_clamp();
      // wall_dist 8: the 9-pixel punch frame stops at 8 and the punch ends.
      do_reset();
      xpos      = 10'd505;
      punch_req = 1'b1;
      tick();
      punch_req = 1'b0;
      compared++;
      if (x_motion !== 11'sd8 || action !== 3'd2) begin
         mismatched++;
         $display("[TB] FAIL clamp_first: got x=%0d act=%0d expected x=8 act=2", x_motion, action);
      end
      xpos = 10'd513;
      for (int i = 0; i < 2; i++) begin
         tick();
         compared++;
         if (x_motion !== 11'sd0 || action !== END_ACTION) begin
            mismatched++;
            $display("[TB] FAIL clamp_after%0d: got x=%0d act=%0d expected x=0 act=%0d",
                     i, x_motion, action, END_ACTION);
         end
      end
      // Sprite already past the bound: a kick frame moves 0.
      do_reset();
      xpos     = 10'd600;
      kick_req = 1'b1;
      tick();
      kick_req = 1'b0;
      compared++;
      if (x_motion !== 11'sd0 || action !== 3'd3) begin
         mismatched++;
         $display("[TB] FAIL clamp_negative: got x=%0d act=%0d expected x=0 act=3", x_motion, action);
      end
      // One pixel of room: walking right moves 1.
      do_reset();
      xpos   = 10'd512;
      walk_r = 1'b1;
      tick();
      walk_r = 1'b0;
      compared++;
      if (x_motion !== 11'sd1 || action !== 3'd1) begin
         mismatched++;
         $display("[TB] FAIL walk_r_wall: got x=%0d act=%0d expected x=1 act=1", x_motion, action);
      end
   endtask

   task automatic test_walk_then_punch();
      do_reset();
      xpos   = 10'd100;
      walk_r = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         compared++;
         if (x_motion !== 11'sd2 || action !== 3'd1 || busy !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL walk_r%0d: got x=%0d act=%0d busy=%0b expected x=2 act=1 busy=0",
                     i, x_motion, action, busy);
         end
      end
      punch_req = 1'b1;
      tick();
      compared++;
      if (x_motion !== 11'sd9 || action !== 3'd2) begin
         mismatched++;
         $display("[TB] FAIL walk_preempt: got x=%0d act=%0d expected x=9 act=2", x_motion, action);
      end
      punch_req = 1'b0;
      walk_r    = 1'b0;
      do_reset();
      xpos   = 10'd1;
      walk_l = 1'b1;
      tick();
      compared++;
      if (x_motion !== -11'sd1 || action !== 3'd1) begin
         mismatched++;
         $display("[TB] FAIL walk_l_edge: got x=%0d act=%0d expected x=-1 act=1", x_motion, action);
      end
      walk_r = 1'b1;
      tick();
      compared++;
      if (x_motion !== 11'sd0 || action !== 3'd0) begin
         mismatched++;
         $display("[TB] FAIL walk_both: got x=%0d act=%0d expected x=0 act=0", x_motion, action);
      end
      walk_l = 1'b0;
      walk_r = 1'b0;
   endtask

   task automatic test_hit_stun();
      do_reset();
      xpos     = 10'd50;
      kick_req = 1'b1;
      tick();
      kick_req = 1'b0;
      tick();
      hit = 1'b1;
      tick();
      hit = 1'b0;
      compared++;
      if (x_motion !== -11'sd3 || action !== 3'd5 || busy !== 1'b1) begin
         mismatched++;
         $display("[TB] FAIL hit_in_kick: got x=%0d act=%0d busy=%0b expected x=-3 act=5 busy=1",
                  x_motion, action, busy);
      end
      for (int i = 0; i < 11; i++) begin
         tick();
         compared++;
         if (x_motion !== 11'sd0 || action !== 3'd5) begin
            mismatched++;
            $display("[TB] FAIL hitstun%0d: got x=%0d act=%0d expected x=0 act=5", i, x_motion, action);
         end
      end
      tick();
      compared++;
      if (action !== 3'd0 || busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL hitstun_exit: got act=%0d busy=%0b expected act=0 busy=0", action, busy);
      end
      // Second hit on the fifth hit-stun frame restarts the full count.
      hit = 1'b1;
      tick();
      hit = 1'b0;
      for (int i = 0; i < 3; i++) tick();
      hit = 1'b1;
      tick();
      hit = 1'b0;
      compared++;
      if (x_motion !== -11'sd3 || action !== 3'd5) begin
         mismatched++;
         $display("[TB] FAIL rehit: got x=%0d act=%0d expected x=-3 act=5", x_motion, action);
      end
      for (int i = 0; i < 11; i++) begin
         tick();
         compared++;
         if (x_motion !== 11'sd0 || action !== 3'd5) begin
            mismatched++;
            $display("[TB] FAIL rehit_stun%0d: got x=%0d act=%0d expected x=0 act=5", i, x_motion, action);
         end
      end
      tick();
      compared++;
      if (action !== 3'd0) begin
         mismatched++;
         $display("[TB] FAIL rehit_exit: got act=%0d expected 0", action);
      end
      // Hit beats crouch, and push-back stops at the left edge.
      do_reset();
      xpos   = 10'd1;
      crouch = 1'b1;
      hit    = 1'b1;
      tick();
      crouch = 1'b0;
      hit    = 1'b0;
      compared++;
      if (x_motion !== -11'sd1 || action !== 3'd5) begin
         mismatched++;
         $display("[TB] FAIL hit_over_crouch: got x=%0d act=%0d expected x=-1 act=5", x_motion, action);
      end
   endtask

   task automatic test_crouch_and_gate();
      do_reset();
      xpos      = 10'd100;
      crouch    = 1'b1;
      punch_req = 1'b1;
      tick();
      compared++;
      if (action !== 3'd0 || x_motion !== 11'sd0 || busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL crouch_punch: got act=%0d x=%0d busy=%0b expected act=0 x=0 busy=0",
                  action, x_motion, busy);
      end
      crouch    = 1'b0;
      punch_req = 1'b0;
      walk_r    = 1'b1;
      tick();
      walk_r    = 1'b0;
      punch_req = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      compared++;
      if (action !== 3'd1 || x_motion !== 11'sd2 || busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL no_tick_hold: got act=%0d x=%0d busy=%0b expected act=1 x=2 busy=0",
                  action, x_motion, busy);
      end
      tick();
      punch_req = 1'b0;
      compared++;
      if (action !== 3'd2 || x_motion !== 11'sd9) begin
         mismatched++;
         $display("[TB] FAIL tick_resume: got act=%0d x=%0d expected act=2 x=9", action, x_motion);
      end
   endtask

   task automatic test_async_reset();
      do_reset();
      xpos      = 10'd100;
      punch_req = 1'b1;
      tick();
      punch_req = 1'b0;
      tick();
      compared++;
      if (action !== 3'd2 || x_motion !== 11'sd8) begin
         mismatched++;
         $display("[TB] FAIL mid_punch: got act=%0d x=%0d expected act=2 x=8", action, x_motion);
      end
      #2;
      Reset = 1'b1;
      #1;
      compared++;
      if (action !== 3'd0 || x_motion !== 11'sd0 || busy !== 1'b0) begin
         mismatched++;
         $display("[TB] FAIL async_clear: got act=%0d x=%0d busy=%0b expected act=0 x=0 busy=0",
                  action, x_motion, busy);
      end
      frame_tick = 1'b1;
      punch_req  = 1'b1;
      @(posedge clk);
      @(negedge clk);
      Reset = 1'b0;
      tick();
      punch_req = 1'b0;
      compared++;
      if (action !== 3'd2 || x_motion !== 11'sd9) begin
         mismatched++;
         $display("[TB] FAIL first_tick_after_reset: got act=%0d x=%0d expected act=2 x=9",
                  action, x_motion);
      end
   endtask

   initial begin
      Reset      = 1'b1;
      frame_tick = 1'b0;
      punch_req  = 1'b0;
      kick_req   = 1'b0;
      walk_l     = 1'b0;
      walk_r     = 1'b0;
      crouch     = 1'b0;
      hit        = 1'b0;
      xpos       = 10'd0;
      test_reset();
      test_punch_sequence();
      test_held_request();
      test_wall_clamp();
      test_walk_then_punch();
      test_hit_stun();
      test_crouch_and_gate();
      test_async_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
